// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory-access stage and MEM/WB pipeline register of the RV32I
//            core. Issues loads/stores over a request/grant/response port,
//            freezes the upstream pipeline while an access is outstanding and
//            registers the write-back result, destination and enable.
// Ports    : clk, rst                     - clock, async active-high reset
//            regWriteM..extImmM           - EX/MEM control and data fields
//            memReq/memWe/memAddr/memBe/memWData - data-memory request side
//            memGnt/memRValid/memRData    - data-memory grant and response
//            stallMem                     - freeze PC, IF/ID, ID/EX, EX/MEM
//            regWriteW/RdW/resultW        - register-file write port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWriteM,
  input  logic        memWriteM,
  input  logic        luiM,
  input  logic [1:0]  resultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] writeDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] extImmM,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWData,
  input  logic        memGnt,
  input  logic        memRValid,
  input  logic [31:0] memRData,
  output logic        stallMem,
  output logic        regWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] resultW
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        w_access;
  logic        w_done;
  logic        w_drive;
  logic [1:0]  w_lane;
  logic [3:0]  w_storeBe;
  logic [31:0] w_storeData;
  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;
  logic [31:0] w_loadData;
  logic [31:0] w_result;

  assign w_access = memWriteM | (resultSrcM == 2'b01);
  assign w_lane   = ALUResultM[1:0];
  // Completion cycle: response arrives while waiting for it.
  assign w_done   = (r_state == S_RESP) & memRValid;
  // Memory-side fields are only driven for an access and forced low in reset.
  assign w_drive  = ~rst & w_access;

  assign stallMem = ~rst & w_access & ~w_done;
  assign memReq   = ~rst & (((r_state == S_IDLE) & w_access) | (r_state == S_REQ));
  assign memWe    = memReq & memWriteM;
  assign memAddr  = w_drive ? {ALUResultM[31:2], 2'b00} : 32'd0;
  assign memBe    = w_drive ? (memWriteM ? w_storeBe : 4'b1111) : 4'b0000;
  assign memWData = (w_drive & memWriteM) ? w_storeData : 32'd0;

  // Store lane steering; misaligned low address bits are ignored.
  always_comb begin
    w_storeBe   = 4'b1111;
    w_storeData = writeDataM;
    case (funct3M[1:0])
      2'b00: begin
        w_storeBe   = 4'b0001 << w_lane;
        w_storeData = {4{writeDataM[7:0]}};
      end
      2'b01: begin
        w_storeBe   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_storeData = {2{writeDataM[15:0]}};
      end
      default: begin
        w_storeBe   = 4'b1111;
        w_storeData = writeDataM;
      end
    endcase
  end

  // Load extraction straight from the response word.
  always_comb begin
    w_loadByte = memRData[7:0];
    case (w_lane)
      2'd0:    w_loadByte = memRData[7:0];
      2'd1:    w_loadByte = memRData[15:8];
      2'd2:    w_loadByte = memRData[23:16];
      default: w_loadByte = memRData[31:24];
    endcase
    w_loadHalf = w_lane[1] ? memRData[31:16] : memRData[15:0];
    case (funct3M)
      3'b000:  w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
      3'b100:  w_loadData = {24'd0, w_loadByte};
      3'b001:  w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
      3'b101:  w_loadData = {16'd0, w_loadHalf};
      default: w_loadData = memRData;
    endcase
  end

  always_comb begin
    w_result = ALUResultM;
    if (luiM) begin
      w_result = extImmM;
    end else begin
      case (resultSrcM)
        2'b01:   w_result = w_loadData;
        2'b10:   w_result = PCPlus4M;
        default: w_result = ALUResultM;
      endcase
    end
  end

  // Access handshake FSM; grant outside a request and response outside
  // RESP are ignored by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_access) r_state <= memGnt ? S_RESP : S_REQ;
        S_REQ:  if (memGnt) r_state <= S_RESP;
        S_RESP: if (memRValid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: a bubble is inserted every cycle the stage is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteW <= 1'b0;
      RdW       <= 5'd0;
      resultW   <= 32'd0;
    end else if (stallMem) begin
      regWriteW <= 1'b0;
      RdW       <= 5'd0;
      resultW   <= 32'd0;
    end else begin
      regWriteW <= regWriteM;
      RdW       <= RdM;
      resultW   <= w_result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Directed self-checking bench for mem_wb_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regWriteM, memWriteM, luiM;
  logic [1:0]  resultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, writeDataM, PCPlus4M, extImmM;
  logic        memReq, memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWData;
  logic        memGnt, memRValid;
  logic [31:0] memRData;
  logic        stallMem, regWriteW;
  logic [4:0]  RdW;
  logic [31:0] resultW;

  int nvec = 0;
  int nerr = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .luiM(luiM),
    .resultSrcM(resultSrcM), .funct3M(funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .writeDataM(writeDataM),
    .PCPlus4M(PCPlus4M), .extImmM(extImmM),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memBe(memBe),
    .memWData(memWData), .memGnt(memGnt), .memRValid(memRValid),
    .memRData(memRData), .stallMem(stallMem),
    .regWriteW(regWriteW), .RdW(RdW), .resultW(resultW)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    regWriteM = 0; memWriteM = 0; luiM = 0; resultSrcM = 2'b00; funct3M = 3'b000;
    RdM = 0; ALUResultM = 0; writeDataM = 0; PCPlus4M = 0; extImmM = 0;
    memGnt = 0; memRValid = 0; memRData = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    memWriteM = 1; resultSrcM = 2'b01; ALUResultM = 32'h0000_0104;
    step();
    nvec++; if (memReq !== 1'b0) begin nerr++; $display("FAIL reset_memReq got %b want 0", memReq); end
    nvec++; if (memWe !== 1'b0) begin nerr++; $display("FAIL reset_memWe got %b want 0", memWe); end
    nvec++; if (memAddr !== 32'd0) begin nerr++; $display("FAIL reset_memAddr got %h want 0", memAddr); end
    nvec++; if (memBe !== 4'd0) begin nerr++; $display("FAIL reset_memBe got %b want 0", memBe); end
    nvec++; if (memWData !== 32'd0) begin nerr++; $display("FAIL reset_memWData got %h want 0", memWData); end
    nvec++; if (stallMem !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", stallMem); end
    nvec++; if ({regWriteW, RdW, resultW} !== 38'd0) begin nerr++; $display("FAIL reset_wb got %b/%0d/%h want 0", regWriteW, RdW, resultW); end
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_nonaccess;
    clear_inputs();
    regWriteM = 1; RdM = 5; ALUResultM = 32'h1234;
    #1;
    nvec++; if (stallMem !== 1'b0) begin nerr++; $display("FAIL nonacc_stall got %b want 0", stallMem); end
    nvec++; if (memReq !== 1'b0) begin nerr++; $display("FAIL nonacc_memReq got %b want 0", memReq); end
    step();
    nvec++; if ({regWriteW, RdW, resultW} !== {1'b1, 5'd5, 32'h1234}) begin nerr++; $display("FAIL nonacc_wb got %b/%0d/%h want 1/5/00001234", regWriteW, RdW, resultW); end
  endtask

  // Load with immediate grant and response one cycle later.
  task automatic test_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
    clear_inputs();
    resultSrcM = 2'b01; funct3M = f3; ALUResultM = addr; regWriteM = 1; RdM = 7; memGnt = 1;
    #1;
    nvec++; if ({memReq, memWe, memBe, stallMem} !== {1'b1, 1'b0, 4'b1111, 1'b1}) begin nerr++; $display("FAIL load_req f3=%b got req=%b we=%b be=%b stall=%b want 1/0/1111/1", f3, memReq, memWe, memBe, stallMem); end
    nvec++; if (memAddr !== {addr[31:2], 2'b00}) begin nerr++; $display("FAIL load_addr got %h want %h", memAddr, {addr[31:2], 2'b00}); end
    step();
    nvec++; if (regWriteW !== 1'b0) begin nerr++; $display("FAIL load_bubble got %b want 0", regWriteW); end
    memGnt = 0; memRValid = 1; memRData = rdata;
    #1;
    nvec++; if ({memReq, stallMem} !== 2'b00) begin nerr++; $display("FAIL load_done got req=%b stall=%b want 0/0", memReq, stallMem); end
    step();
    nvec++; if ({regWriteW, RdW, resultW} !== {1'b1, 5'd7, exp}) begin nerr++; $display("FAIL load_wb f3=%b got %b/%0d/%h want 1/7/%h", f3, regWriteW, RdW, resultW, exp); end
    memRValid = 0;
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] expBe, input logic [31:0] expWd);
    clear_inputs();
    memWriteM = 1; funct3M = f3; ALUResultM = addr; writeDataM = wd; regWriteM = 1; RdM = 3; memGnt = 1;
    #1;
    nvec++; if ({memReq, memWe, stallMem} !== 3'b111) begin nerr++; $display("FAIL store_req got req=%b we=%b stall=%b want 111", memReq, memWe, stallMem); end
    nvec++; if (memBe !== expBe) begin nerr++; $display("FAIL store_be f3=%b addr=%h got %b want %b", f3, addr, memBe, expBe); end
    nvec++; if (memWData !== expWd) begin nerr++; $display("FAIL store_wdata got %h want %h", memWData, expWd); end
    nvec++; if (memAddr !== {addr[31:2], 2'b00}) begin nerr++; $display("FAIL store_addr got %h want %h", memAddr, {addr[31:2], 2'b00}); end
    step();
    nvec++; if (regWriteW !== 1'b0) begin nerr++; $display("FAIL store_bubble got %b want 0", regWriteW); end
    memGnt = 0; memRValid = 1;
    #1;
    nvec++; if ({stallMem, memReq} !== 2'b00) begin nerr++; $display("FAIL store_done got stall=%b req=%b want 00", stallMem, memReq); end
    step();
    memRValid = 0;
  endtask

  // Grant after 3 wait cycles, response after 2 more, stray responses early.
  task automatic test_delayed;
    logic [6:0] gnt_t;
    logic [6:0] rv_t;
    int reqc, stallc, writes, wcycle;
    gnt_t = 7'b0001000;   // bit i = cycle i
    rv_t  = 7'b1000011;
    reqc = 0; stallc = 0; writes = 0; wcycle = -1;
    clear_inputs();
    resultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h200; regWriteM = 1; RdM = 9;
    memRData = 32'hCAFE_F00D;
    for (int i = 0; i < 7; i++) begin
      memGnt = gnt_t[i]; memRValid = rv_t[i];
      #1;
      if (memReq === 1'b1) reqc++;
      if (stallMem === 1'b1) stallc++;
      nvec++; if (memReq !== (i <= 3)) begin nerr++; $display("FAIL delay_req cycle %0d got %b want %b", i, memReq, (i <= 3)); end
      step();
      if (regWriteW === 1'b1) begin writes++; wcycle = i; end
    end
    nvec++; if (reqc !== 4) begin nerr++; $display("FAIL delay_reqcount got %0d want 4", reqc); end
    nvec++; if (stallc !== 6) begin nerr++; $display("FAIL delay_stallcount got %0d want 6", stallc); end
    nvec++; if (writes !== 1 || wcycle !== 6) begin nerr++; $display("FAIL delay_writes got %0d at %0d want 1 at 6", writes, wcycle); end
    nvec++; if ({RdW, resultW} !== {5'd9, 32'hCAFE_F00D}) begin nerr++; $display("FAIL delay_wb got %0d/%h want 9/cafef00d", RdW, resultW); end
    memRValid = 0;
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    regWriteM = 1; RdM = 4; ALUResultM = 32'h55;
    step();
    rst = 1;
    #1;
    nvec++; if ({regWriteW, RdW, resultW} !== 38'd0) begin nerr++; $display("FAIL async_rst_wb got %b/%0d/%h want 0", regWriteW, RdW, resultW); end
    step();
    rst = 0;
    clear_inputs();
    resultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h300; regWriteM = 1; RdM = 6; memGnt = 1;
    step();                       // now waiting for response
    memGnt = 0; rst = 1;
    #1;
    nvec++; if ({memReq, memBe, memAddr, stallMem} !== 38'd0) begin nerr++; $display("FAIL midrst_out got req=%b be=%b addr=%h stall=%b want 0", memReq, memBe, memAddr, stallMem); end
    step();
    rst = 0; memRValid = 1; memRData = 32'h1111_2222;
    #1;
    nvec++; if ({memReq, stallMem} !== 2'b11) begin nerr++; $display("FAIL midrst_idle got req=%b stall=%b want 11", memReq, stallMem); end
    step();
    nvec++; if (regWriteW !== 1'b0) begin nerr++; $display("FAIL midrst_stale got %b want 0", regWriteW); end
    memRValid = 0; memGnt = 1;
    step();
    memGnt = 0; memRValid = 1; memRData = 32'h3333_4444;
    step();
    nvec++; if ({regWriteW, RdW, resultW} !== {1'b1, 5'd6, 32'h3333_4444}) begin nerr++; $display("FAIL midrst_recover got %b/%0d/%h want 1/6/33334444", regWriteW, RdW, resultW); end
    memRValid = 0;
  endtask

  task automatic test_lui_jal;
    clear_inputs();
    luiM = 1; extImmM = 32'h1234_5000; ALUResultM = 32'hDEAD; regWriteM = 1; RdM = 1;
    step();
    nvec++; if ({RdW, resultW} !== {5'd1, 32'h1234_5000}) begin nerr++; $display("FAIL lui got %0d/%h want 1/12345000", RdW, resultW); end
    clear_inputs();
    resultSrcM = 2'b10; PCPlus4M = 32'h44; ALUResultM = 32'hDEAD; regWriteM = 1; RdM = 2;
    #1;
    nvec++; if (stallMem !== 1'b0) begin nerr++; $display("FAIL jal_stall got %b want 0", stallMem); end
    step();
    nvec++; if ({RdW, resultW} !== {5'd2, 32'h44}) begin nerr++; $display("FAIL jal got %0d/%h want 2/00000044", RdW, resultW); end
    clear_inputs();
    resultSrcM = 2'b11; PCPlus4M = 32'h44; ALUResultM = 32'h77; regWriteM = 1; RdM = 3;
    step();
    nvec++; if (resultW !== 32'h77) begin nerr++; $display("FAIL src11 got %h want 00000077", resultW); end
  endtask

  initial begin
    test_reset();
    test_nonaccess();
    // Loads issued back to back: each new request follows its predecessor's completion.
    test_load(3'b000, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    test_load(3'b100, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    test_load(3'b000, 32'h101, 32'h1234_5678, 32'h0000_0056);
    test_load(3'b001, 32'h102, 32'h8001_1234, 32'hFFFF_8001);
    test_load(3'b101, 32'h102, 32'h8001_1234, 32'h0000_8001);
    test_load(3'b001, 32'h100, 32'h8001_F234, 32'hFFFF_F234);
    test_load(3'b010, 32'h107, 32'h89AB_CDEF, 32'h89AB_CDEF);
    test_store(3'b001, 32'h102, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF);
    test_store(3'b001, 32'h100, 32'hAAAA_BEEF, 4'b0011, 32'hBEEF_BEEF);
    test_store(3'b000, 32'h101, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    test_store(3'b000, 32'h103, 32'h1234_5678, 4'b1000, 32'h7878_7878);
    test_store(3'b010, 32'h203, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    test_delayed();
    test_reset_mid();
    test_lui_jal();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
